// File: rtl/divu_seq_if.sv
// Start/busy/valid handshake bundle for the sequential unsigned divider.
// Port r exists only when DIVU_REM_EN is defined.
interface divu_seq_if #(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 4
);
    logic               start;
    logic [N_WIDTH-1:0] n;
    logic [D_WIDTH-1:0] d;
    logic [N_WIDTH-1:0] q;
`ifdef DIVU_REM_EN
    logic [D_WIDTH-1:0] r;
`endif
    logic               busy;
    logic               valid;
    logic               div_zero;

    modport master (
        output start, n, d,
`ifdef DIVU_REM_EN
        input  r,
`endif
        input  q, busy, valid, div_zero
    );

    modport slave (
        input  start, n, d,
`ifdef DIVU_REM_EN
        output r,
`endif
        output q, busy, valid, div_zero
    );
endinterface

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIVU_REM_EN to expose the final remainder on port r.
module divu_seq #(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    divu_seq_if.slave bus
);
    localparam int CW = $clog2(N_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [N_WIDTH-1:0] dvd;
    logic [N_WIDTH-1:0] quo;
    logic [D_WIDTH-1:0] dsr;
    logic [D_WIDTH-1:0] rem;
    logic [D_WIDTH-1:0] rem_nxt;
    logic [D_WIDTH:0]   rem_sh;
    logic [D_WIDTH:0]   rem_sub;
    logic               fit;
    logic               dz;

    // Remainder stays below the divisor, so D_WIDTH bits always hold it.
    always_comb begin
        rem_sh  = {rem, dvd[N_WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dsr};
        fit     = rem_sh >= {1'b0, dsr};
        rem_nxt = D_WIDTH'(fit ? rem_sub : rem_sh);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = (bus.d == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dvd <= '0;
            dsr <= '0;
            rem <= '0;
            quo <= '0;
            dz  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd <= bus.n;
                        dsr <= bus.d;
                        rem <= '0;
                        cnt <= CW'(N_WIDTH);
                        dz  <= (bus.d == '0);
                        quo <= (bus.d == '0) ? '1 : '0;
                    end
                end
                BUSY: begin
                    dvd <= dvd << 1;
                    rem <= rem_nxt;
                    quo <= {quo[N_WIDTH-2:0], fit};
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.q        = quo;
    assign bus.busy     = (state == BUSY);
    assign bus.valid    = (state == DONE);
    assign bus.div_zero = dz;
`ifdef DIVU_REM_EN
    assign bus.r        = rem;
`endif

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: directed vectors plus a full n/d sweep.
// Remainder is compared only when DIVU_REM_EN is defined.
module tb_divu_seq;
    localparam int NW = 8;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divu_seq_if #(.N_WIDTH(NW), .D_WIDTH(DW)) bus ();

    divu_seq #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int q;
        int r;
        int dz;
        int lat;
        int t0;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic vprev      = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation on every rising valid.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (bus.busy && bus.valid) begin
            mismatched++;
            $display("FAIL busy_valid_both_high at cycle %0d", cyc);
        end
        if (bus.valid && !vprev) begin
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("q", 32'(bus.q), 32'(e.q));
`ifdef DIVU_REM_EN
                chk("r", 32'(bus.r), 32'(e.r));
`endif
                chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("busy_at_valid", 32'(bus.busy), 32'd0);
            end
        end
        vprev = bus.valid;
    end

    task automatic issue(input int nv, input int dv, input int eq,
                         input int er, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = NW'(nv);
        bus.d     = DW'(dv);
        @(negedge clk);
        bus.start = 1'b0;
        if (push) begin
            sb.push_back('{q: eq, r: er, dz: (dv == 0) ? 1 : 0,
                           lat: (dv == 0) ? 0 : NW, t0: cyc});
        end
    endtask

    task automatic wait_valid(input int limit);
        int i;
        i = 0;
        while (!bus.valid && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (!bus.valid) begin
            mismatched++;
            $display("FAIL wait_valid: got timeout expected valid");
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"}, 32'(bus.q), 32'd0);
`ifdef DIVU_REM_EN
        chk({tag, "_r"}, 32'(bus.r), 32'd0);
`endif
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_dz"}, 32'(bus.div_zero), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;
        bus.d     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        // Divide by zero from IDLE: done on the start edge.
        issue(8'hAA, 0, 255, 0, 1'b1);
        chk("dz_valid", 32'(bus.valid), 32'd1);
        chk("dz_busy", 32'(bus.busy), 32'd0);
        chk("dz_q", 32'(bus.q), 32'd255);
        chk("dz_flag", 32'(bus.div_zero), 32'd1);
        repeat (2) @(negedge clk);

        // 200 / 7 started from DONE, busy for exactly NW cycles.
        issue(200, 7, 28, 4, 1'b1);
        chk("drop_valid", 32'(bus.valid), 32'd0);
        nb = 0;
        for (int i = 0; i < 20 && !bus.valid; i++) begin
            nb += int'(bus.busy);
            @(negedge clk);
        end
        chk("busy_cycles", 32'(nb), 32'd8);
        wait_valid(NW + 4);
        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(bus.valid), 32'd1);
        chk("hold_q", 32'(bus.q), 32'd28);

        // Back-to-back corners.
        issue(255, 15, 17, 0, 1'b1);
        wait_valid(NW + 4);
        issue(5, 9, 0, 5, 1'b1);
        chk("b2b_drop_valid", 32'(bus.valid), 32'd0);
        wait_valid(NW + 4);

        // Start while busy is ignored; inputs may change after capture.
        issue(100, 3, 33, 1, 1'b1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.n     = 8'd1;
        bus.d     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.n     = 8'd77;
        bus.d     = 4'd5;
        wait_valid(NW + 4);

        // Reset on busy cycle 4 aborts with no result.
        issue(200, 7, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        issue(9, 2, 4, 1, 1'b1);
        wait_valid(NW + 4);

        for (int nv = 0; nv < 256; nv++) begin
            for (int dv = 1; dv < 16; dv++) begin
                issue(nv, dv, nv / dv, nv % dv, 1'b1);
                wait_valid(NW + 4);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
